// File: rtl/fpga_pio_pkg.sv
// Shared register map and constants for the HPS-facing LED/switch responder.
// Word addresses, the default ID word and the blink period width.
package fpga_pio_pkg;

  localparam logic [2:0] ADDR_LED          = 3'd0;
  localparam logic [2:0] ADDR_SW           = 3'd1;
  localparam logic [2:0] ADDR_EDGE         = 3'd2;
  localparam logic [2:0] ADDR_MASK         = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN     = 3'd4;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_ID           = 3'd6;

  localparam logic [31:0] ID_DEFAULT = 32'h4C45_4431;

  localparam int BLINK_PERIOD_W = 16;

endpackage

// File: rtl/fpga_pio_responder_sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a consecutive-cycle debounce counter.
// sw_chg pulses in the cycle whose closing edge updates sw_db.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_chg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt_p2;

  assign sw_chg = (sync_p1 != sw_db) && (cnt_p2 == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt_p2  <= '0;
      sw_db   <= 1'b0;
    end else begin
      // synchroniser stages
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
      // debounce stage: any agreeing cycle restarts the count
      if (sync_p1 == sw_db) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
        cnt_p2 <= '0;
        sw_db  <= sync_p1;
      end else begin
        cnt_p2 <= cnt_p2 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_pio_responder.sv
// Avalon-MM responder on the lightweight h2f bridge: LED register with blink engine,
// debounced switches, switch edge capture and a maskable level interrupt.
module fpga_pio_responder
  import fpga_pio_pkg::*;
#(
  parameter int          N_LED           = 4,
  parameter int          N_SW            = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          PRESCALE        = 50000,
  parameter logic [31:0] ID_VALUE        = ID_DEFAULT
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_LED-1:0] ledr_export
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [N_LED-1:0]          led_data;
  logic [N_SW-1:0]           sw_state;
  logic [N_SW-1:0]           sw_chg;
  logic [N_SW-1:0]           sw_edge;
  logic [N_SW-1:0]           mask;
  logic [N_LED-1:0]          blink_en;
  logic [BLINK_PERIOD_W-1:0] blink_period;
  logic [PW-1:0]             presc_cnt;
  logic [BLINK_PERIOD_W-1:0] per_cnt;
  logic                      phase;
  logic                      tick;
  logic [31:0]               rd_mux;
  logic [N_SW-1:0]           edge_nxt;
  logic                      wr_led, wr_edge, wr_mask, wr_blink_en, wr_period;
  logic                      unused_wdata;

  assign unused_wdata = &{1'b0, avs_writedata[31:BLINK_PERIOD_W]};

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .sw_raw(sw_in[i]),
      .sw_db (sw_state[i]),
      .sw_chg(sw_chg[i])
    );
  end

  assign wr_led      = avs_write && (avs_address == ADDR_LED);
  assign wr_edge     = avs_write && (avs_address == ADDR_EDGE);
  assign wr_mask     = avs_write && (avs_address == ADDR_MASK);
  assign wr_blink_en = avs_write && (avs_address == ADDR_BLINK_EN);
  assign wr_period   = avs_write && (avs_address == ADDR_BLINK_PERIOD);

  // A debounced edge in the same cycle as a W1C keeps the bit set.
  assign edge_nxt = (sw_edge & ~(wr_edge ? avs_writedata[N_SW-1:0] : '0)) | sw_chg;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_LED:          rd_mux[N_LED-1:0]          = led_data;
      ADDR_SW:           rd_mux[N_SW-1:0]           = sw_state;
      ADDR_EDGE:         rd_mux[N_SW-1:0]           = sw_edge;
      ADDR_MASK:         rd_mux[N_SW-1:0]           = mask;
      ADDR_BLINK_EN:     rd_mux[N_LED-1:0]          = blink_en;
      ADDR_BLINK_PERIOD: rd_mux[BLINK_PERIOD_W-1:0] = blink_period;
      ADDR_ID:           rd_mux                     = ID_VALUE;
      default:           rd_mux                     = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      led_data          <= '0;
      sw_edge           <= '0;
      mask              <= '0;
      blink_en          <= '0;
      blink_period      <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      irq               <= 1'b0;
      ledr_export       <= '0;
    end else begin
      if (wr_led)      led_data     <= avs_writedata[N_LED-1:0];
      if (wr_mask)     mask         <= avs_writedata[N_SW-1:0];
      if (wr_blink_en) blink_en     <= avs_writedata[N_LED-1:0];
      if (wr_period)   blink_period <= avs_writedata[BLINK_PERIOD_W-1:0];
      sw_edge <= edge_nxt;
      // read response stage: mux sees pre-write register values
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
      // output stage
      irq         <= |(sw_edge & mask);
      ledr_export <= led_data & ~(blink_en & {N_LED{~phase}});
    end
  end

  assign tick = (presc_cnt == PRESCALE_LAST);

  always_ff @(posedge clk_clk) begin
    if (reset_reset || wr_period || (blink_period == '0)) begin
      presc_cnt <= '0;
      per_cnt   <= '0;
      phase     <= 1'b1;
    end else if (tick) begin
      presc_cnt <= '0;
      if (per_cnt == blink_period - 1'b1) begin
        per_cnt <= '0;
        phase   <= ~phase;
      end else begin
        per_cnt <= per_cnt + 1'b1;
      end
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_pio_responder.sv
// Directed bench for fpga_pio_responder with DEBOUNCE_CYCLES=4, PRESCALE=2.
// Reads push expected data into a queue; a forked monitor pops it on avs_readdatavalid.
module tb_fpga_pio_responder;

  localparam logic [31:0] ID = 32'h4C45_4431;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [3:0]  sw_in;
  logic [3:0]  ledr_export;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_clk = ~clk_clk;

  fpga_pio_responder #(
    .N_LED(4), .N_SW(4), .DEBOUNCE_CYCLES(4), .PRESCALE(2), .ID_VALUE(ID)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .irq(irq),
    .sw_in(sw_in),
    .ledr_export(ledr_export)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    rd_exp_t e;
    forever begin
      @(negedge clk_clk);
      if (avs_readdatavalid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_readdatavalid: got %b, expected 0 at %0t", avs_readdatavalid, $time);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("read_addr%0d", e.addr), avs_readdata, e.val);
        end
      end
    end
  endtask

  // Every bus task starts and ends on a falling edge and spans one clock.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a; e.val = exp;
    exp_q.push_back(e);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a; e.val = exp;
    exp_q.push_back(e);
    avs_address = a; avs_writedata = d; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; sw_in = '0;
    fork monitor(); join_none
    idle(3);
    chk("reset_ledr", 32'(ledr_export), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_rdv", 32'(avs_readdatavalid), 32'h0);
    chk("reset_readdata", avs_readdata, 32'h0);
    reset_reset = 1'b0;

    rd(3'd6, ID);
    rd(3'd1, 32'h0);

    // LED register and RO write
    wr(3'd0, 32'hA);
    chk("ledr_before", 32'(ledr_export), 32'h0);
    idle(1);
    chk("ledr_after", 32'(ledr_export), 32'hA);
    rd(3'd0, 32'hA);
    wr(3'd1, 32'hF);
    rd(3'd1, 32'h0);

    // 3-cycle glitch must be rejected
    sw_in = 4'b0001;
    idle(3);
    sw_in = 4'b0000;
    idle(8);
    rd(3'd1, 32'h0);
    rd(3'd2, 32'h0);

    // held change: read at edge 6 sees old value, edge 7 sees new
    sw_in = 4'b0001;
    idle(5);
    rd(3'd1, 32'h0);
    rd(3'd1, 32'h1);
    rd(3'd2, 32'h1);

    wr(3'd3, 32'h1);
    chk("irq_mask_lag", 32'(irq), 32'h0);
    idle(1);
    chk("irq_masked_on", 32'(irq), 32'h1);

    // W1C on the same edge as a new debounced falling edge
    sw_in = 4'b0000;
    idle(5);
    wr(3'd2, 32'h1);
    chk("irq_collide0", 32'(irq), 32'h1);
    idle(1);
    chk("irq_collide1", 32'(irq), 32'h1);
    rd(3'd2, 32'h1);
    rd(3'd1, 32'h0);

    wr(3'd2, 32'h1);
    chk("irq_w1c_lag", 32'(irq), 32'h1);
    idle(1);
    chk("irq_w1c_clear", 32'(irq), 32'h0);
    rd(3'd2, 32'h0);

    // blink: period 3 ticks of 2 clocks
    wr(3'd0, 32'hF);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h3);
    chk("blink_k0", 32'(ledr_export), 32'hF);
    for (int k = 1; k <= 24; k++) begin
      idle(1);
      chk($sformatf("blink_k%0d", k), 32'(ledr_export), ((((k - 1) / 6) % 2) == 1) ? 32'hE : 32'hF);
    end
    idle(7);
    chk("blink_off_phase", 32'(ledr_export), 32'hE);
    wr(3'd5, 32'h0);
    chk("halt_lag", 32'(ledr_export), 32'hE);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      chk($sformatf("halt_k%0d", k), 32'(ledr_export), 32'hF);
    end
    rd(3'd5, 32'h0);
    rd(3'd4, 32'h1);

    // same-cycle read and write returns the old value
    wr(3'd3, 32'h0);
    rdwr(3'd3, 32'h3, 32'h0);
    rd(3'd3, 32'h3);
    chk("irq_no_edge", 32'(irq), 32'h0);

    // unused/RO addresses and upper bits
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'h0);
    wr(3'd6, 32'h0);
    rd(3'd6, ID);
    wr(3'd0, 32'hFFFF_FFF5);
    rd(3'd0, 32'h5);
    chk("ledr_5", 32'(ledr_export), 32'h5);

    // reset together with a read strobe discards the response
    avs_address = 3'd0; avs_read = 1'b1; reset_reset = 1'b1;
    idle(1);
    avs_read = 1'b0;
    chk("rst_rdv", 32'(avs_readdatavalid), 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_ledr", 32'(ledr_export), 32'h0);
    reset_reset = 1'b0;
    rd(3'd0, 32'h0);
    rd(3'd2, 32'h0);
    rd(3'd3, 32'h0);
    rd(3'd4, 32'h0);
    rd(3'd5, 32'h0);
    idle(1);
    chk("post_rst_ledr", 32'(ledr_export), 32'h0);
    chk("post_rst_irq", 32'(irq), 32'h0);

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
